// File: rtl/world_loader_pkg.sv
// Shared voxel-world types and constants for the world loader and its consumers.
package world_loader_pkg;

  localparam int WORLD_LENGTH = 64;
  localparam int WORLD_WIDTH  = 64;
  localparam int WORLD_HEIGHT = 16;
  localparam int WORLD_DEPTH  = WORLD_LENGTH * WORLD_WIDTH * WORLD_HEIGHT;

  localparam logic [7:0] SYNC_BULK = 8'hA5;
  localparam logic [7:0] SYNC_UPD  = 8'h5A;

  typedef logic [7:0] block_type_t;

  typedef struct packed {
    logic [$clog2(WORLD_HEIGHT)-1:0] y;
    logic [$clog2(WORLD_WIDTH)-1:0]  z;
    logic [$clog2(WORLD_LENGTH)-1:0] x;
  } block_pos_t;

  typedef struct packed {
    block_pos_t  pos;
    block_type_t blk;
  } voxel_wr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BULK,
    ST_UPD_X,
    ST_UPD_Y,
    ST_UPD_Z,
    ST_UPD_T
  } loader_state_t;

  function automatic logic coord_in_range(input logic [7:0] c, input int extent);
    return int'(c) < extent;
  endfunction

endpackage

// File: rtl/world_loader_sync_fifo.sv
// Small synchronous valid/ready FIFO; simultaneous push and pop while full both succeed.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is pure data; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/world_loader.sv
// Turns the plugin's UART byte stream into voxel cache writes (bulk world load and single-block patches).
module world_loader
  import world_loader_pkg::*;
#(
  parameter int         LENGTH    = world_loader_pkg::WORLD_LENGTH,
  parameter int         WIDTH     = world_loader_pkg::WORLD_WIDTH,
  parameter int         HEIGHT    = world_loader_pkg::WORLD_HEIGHT,
  parameter logic [7:0] SYNC_BULK = world_loader_pkg::SYNC_BULK,
  parameter logic [7:0] SYNC_UPD  = world_loader_pkg::SYNC_UPD,
  parameter int         TIMEOUT   = 1_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in,
  output logic [15:0] wr_addr_out,
  output logic [7:0]  wr_data_out,
  output logic        wr_valid_out,
  input  logic        wr_ready_in,
  output logic        initialized_out,
  output logic        busy_out,
  output logic [2:0]  err_out
);

  localparam int DEPTH = LENGTH * WIDTH * HEIGHT;
  localparam int XW    = $clog2(LENGTH);
  localparam int ZW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int CW    = $bits(block_pos_t);
  localparam int TW    = $clog2(TIMEOUT + 1);

  loader_state_t   state;
  loader_state_t   state_nx;
  logic [CW-1:0]   cnt;
  logic            cnt_last;
  logic [TW-1:0]   to_cnt;
  logic            timeout_hit;
  logic [7:0]      x_q, y_q, z_q;
  logic            init_q;
  logic [2:0]      err_q;

  logic            push;
  voxel_wr_t       push_data;
  voxel_wr_t       upd_wr;
  logic            cnt_clr, cnt_inc, set_init, clr_init;
  logic            err_to, err_range, err_ovf;
  logic            upd_ok;

  logic [$bits(voxel_wr_t)-1:0] head;
  logic            empty, full;

  assign cnt_last    = (cnt == CW'(DEPTH - 1));
  assign timeout_hit = (state != ST_IDLE) && !rx_valid_in && (to_cnt == TW'(TIMEOUT - 1));
  assign upd_ok      = coord_in_range(x_q, LENGTH) && coord_in_range(y_q, HEIGHT)
                       && coord_in_range(z_q, WIDTH);

  always_comb begin
    upd_wr.pos.y = y_q[YW-1:0];
    upd_wr.pos.z = z_q[ZW-1:0];
    upd_wr.pos.x = x_q[XW-1:0];
    upd_wr.blk   = rx_data_in;
  end

  always_comb begin
    state_nx  = state;
    push      = 1'b0;
    push_data = '0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    set_init  = 1'b0;
    clr_init  = 1'b0;
    err_to    = 1'b0;
    err_range = 1'b0;
    if (rx_valid_in) begin
      // Inside a packet every byte is payload, including sync values.
      unique case (state)
        ST_IDLE: begin
          if (rx_data_in == SYNC_BULK) begin
            state_nx = ST_BULK;
            cnt_clr  = 1'b1;
            clr_init = 1'b1;
          end else if (rx_data_in == SYNC_UPD) begin
            state_nx = ST_UPD_X;
          end
        end
        ST_BULK: begin
          push      = 1'b1;
          push_data = {cnt, rx_data_in};
          cnt_inc   = 1'b1;
          if (cnt_last) begin
            set_init = 1'b1;
            state_nx = ST_IDLE;
          end
        end
        ST_UPD_X: state_nx = ST_UPD_Y;
        ST_UPD_Y: state_nx = ST_UPD_Z;
        ST_UPD_Z: state_nx = ST_UPD_T;
        ST_UPD_T: begin
          state_nx  = ST_IDLE;
          push      = upd_ok;
          push_data = upd_wr;
          err_range = !upd_ok;
        end
        default: state_nx = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nx = ST_IDLE;
      err_to   = 1'b1;
    end
  end

  // Dropped entries still advance cnt so later bulk bytes land at their true address.
  assign err_ovf = push && full && !wr_ready_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      to_cnt <= '0;
      init_q <= 1'b0;
      err_q  <= '0;
    end else begin
      state <= state_nx;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt_last ? '0 : cnt + 1'b1;
      if (rx_valid_in || state == ST_IDLE) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + 1'b1;
      if (clr_init)      init_q <= 1'b0;
      else if (set_init) init_q <= 1'b1;
      err_q <= err_q | {err_to, err_range, err_ovf};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rx_valid_in) begin
      case (state)
        ST_UPD_X: x_q <= rx_data_in;
        ST_UPD_Y: y_q <= rx_data_in;
        ST_UPD_Z: z_q <= rx_data_in;
        default: ;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH($bits(voxel_wr_t)),
    .DEPTH(2)
  ) u_fifo (
    .clk      (clk_in),
    .rst_n    (rst_in),
    .push     (push),
    .push_data(push_data),
    .pop      (wr_ready_in),
    .head     (head),
    .empty    (empty),
    .full     (full)
  );

  assign wr_valid_out               = !empty;
  assign {wr_addr_out, wr_data_out} = empty ? '0 : head;
  assign initialized_out            = init_q;
  assign busy_out                   = (state != ST_IDLE);
  assign err_out                    = err_q;

endmodule

// File: tb/tb_world_loader.sv
// Scoreboard bench for world_loader: directed byte streams, expected writes queued, monitor compares.
module tb_world_loader;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        wr_ready = 1'b0;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        initialized;
  logic        busy;
  logic [2:0]  err;

  int          total = 0;
  int          bad = 0;
  logic [23:0] sb[$];
  logic [23:0] mon_exp;

  always #5 clk = ~clk;

  world_loader #(.TIMEOUT(TO)) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .rx_data_in     (rx_data),
    .rx_valid_in    (rx_valid),
    .wr_addr_out    (wr_addr),
    .wr_data_out    (wr_data),
    .wr_valid_out   (wr_valid),
    .wr_ready_in    (wr_ready),
    .initialized_out(initialized),
    .busy_out       (busy),
    .err_out        (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshakes are judged late in the low phase, after the driver has settled.
  always @(negedge clk) begin
    #3;
    if (rst_n && wr_valid && wr_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got %h_%h expected none", wr_addr, wr_data);
      end else begin
        mon_exp = sb.pop_front();
        chk("write", {8'h0, wr_addr, wr_data}, {8'h0, mon_exp});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
    sb.push_back({a, d});
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'h0, wr_valid}, 32'h0);
    chk("rst_init",  {31'h0, initialized}, 32'h0);
    chk("rst_busy",  {31'h0, busy}, 32'h0);
    chk("rst_err",   {29'h0, err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < TO + 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    @(negedge clk);

    // Full world load
    do_reset();
    wr_ready = 1'b1;
    send(8'hA5);
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = 16'(i);
      expect_wr(a, a[7:0]);
      if (i == 65535) chk("init_before_last", {31'h0, initialized}, 32'h0);
      send(a[7:0]);
    end
    chk("init_after_last", {31'h0, initialized}, 32'h1);
    drain();
    chk("bulk_err", {29'h0, err}, 32'h0);
    chk("bulk_busy", {31'h0, busy}, 32'h0);

    // Single-block update before initialization
    do_reset();
    wr_ready = 1'b1;
    send(8'h5A); send(8'h03); send(8'h02); send(8'h01);
    expect_wr(16'h2043, 8'h07);
    send(8'h07);
    chk("upd_latency_valid", {31'h0, wr_valid}, 32'h1);
    drain();
    chk("upd_init", {31'h0, initialized}, 32'h0);
    chk("upd_err", {29'h0, err}, 32'h0);

    // Out-of-range coordinate
    send(8'h5A); send(8'h40); send(8'h00); send(8'h00); send(8'h09);
    repeat (5) @(negedge clk);
    chk("range_err", {29'h0, err}, 32'h2);
    chk("range_busy", {31'h0, busy}, 32'h0);
    chk("range_nowrite", sb.size(), 0);

    // Backpressure and overflow
    do_reset();
    wr_ready = 1'b0;
    send(8'hA5);
    expect_wr(16'h0000, 8'h10);
    expect_wr(16'h0001, 8'h11);
    send(8'h10); send(8'h11); send(8'h12);
    chk("bp_valid", {31'h0, wr_valid}, 32'h1);
    chk("bp_head", {8'h0, wr_addr, wr_data}, 32'h0000_0010);
    chk("ovf_err", {29'h0, err}, 32'h1);
    repeat (3) @(negedge clk);
    chk("bp_stable", {8'h0, wr_addr, wr_data}, 32'h0000_0010);
    wr_ready = 1'b1;
    drain();
    expect_wr(16'h0003, 8'h13);
    send(8'h13);
    drain();

    // Timeout inside a bulk packet
    do_reset();
    wr_ready = 1'b1;
    send(8'hA5);
    for (int i = 0; i < 10; i++) begin
      expect_wr(16'(i), 8'(8'h20 + i));
      send(8'(8'h20 + i));
    end
    chk("to_busy_before", {31'h0, busy}, 32'h1);
    wait_idle("to_busy_after");
    chk("to_err", {29'h0, err}, 32'h4);
    chk("to_init", {31'h0, initialized}, 32'h0);
    drain();
    send(8'hA5);
    expect_wr(16'h0000, 8'h77);
    send(8'h77);
    drain();
    wait_idle("to_busy_again");

    // Asynchronous reset mid-update
    send(8'h5A); send(8'h03);
    chk("mid_busy", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy",  {31'h0, busy}, 32'h0);
    chk("async_err",   {29'h0, err}, 32'h0);
    chk("async_valid", {31'h0, wr_valid}, 32'h0);
    chk("async_init",  {31'h0, initialized}, 32'h0);
    chk("async_addr",  {8'h0, wr_addr, wr_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h5A); send(8'h01); send(8'h01); send(8'h01);
    expect_wr(16'h1041, 8'h05);
    send(8'h05);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
